sigma_x_seq_mc: RTL

Multi-channel Sigma-X pulse sequencer with a hardened safety interlock. This is the parametrised successor to the single-channel trigger/SCRAM checker.
- Accepts pulse commands over a valid/ready handshake.
- Validates width against adiabatic and thermal limits.
- Drives one of CH_N pulse lines for an exact tick count, then enforces an inter-pulse gap.
- Sits between the host command FIFO and the braid drive DACs.
- safety_scram feeds the cryostat interlock chain.

---
 rtl/sigma_x_seq_mc.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sigma_x_seq_mc.sv
// sigma_x_seq_mc: multi-channel Sigma-X pulse sequencer with latched safety SCRAM interlock.
// Latency: pulse rises 1 cycle after accept; done strobes width + GAP_TICKS + 1 cycles after accept.
// Backpressure: cmd_ready only in IDLE with no SCRAM and no ext_fault; optional duty limit via SIGMA_SEQ_DUTY_LIMIT_EN.
module sigma_x_seq_mc #(
  parameter int CH_N      = 4,
  parameter int W_W       = 8,
  parameter int MIN_TICKS = 10,
  parameter int MAX_TICKS = 200,
  parameter int GAP_TICKS = 4,
`ifdef SIGMA_SEQ_DUTY_LIMIT_EN
  parameter int DUTY_WIN  = 1024,
  parameter int DUTY_MAX  = 8,
`endif
  parameter int CH_W      = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CH_W-1:0] cmd_ch,
  input  logic [W_W-1:0]  cmd_width,
  input  logic            ext_fault,
  input  logic            scram_clear,
  output logic [CH_N-1:0] pulse_out,
  output logic            busy,
  output logic            done,
  output logic            safety_scram,
  output logic [2:0]      scram_cause
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_SCRAM = 2'd3
  } state_t;

  localparam logic [2:0] CAUSE_NONE  = 3'b000;
  localparam logic [2:0] CAUSE_SHORT = 3'b001;
  localparam logic [2:0] CAUSE_LONG  = 3'b010;
  localparam logic [2:0] CAUSE_CH    = 3'b011;
  localparam logic [2:0] CAUSE_FAULT = 3'b100;

  // The gap reuses the pulse down-counter, so it is loaded with GAP_TICKS-1.
  localparam logic [W_W-1:0] GAP_LOAD = W_W'(GAP_TICKS - 1);

  state_t          state_q, state_d;
  logic [W_W-1:0]  cnt_q, cnt_d;
  logic [CH_N-1:0] pulse_q, pulse_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            scram_q, scram_d;
  logic [2:0]      cause_q, cause_d;

  logic            accept;
  logic            pulse_start;
  logic [2:0]      chk_cause;

  // Only an idle, healthy sequencer takes commands; a live fault blocks the accept in the same cycle.
  assign cmd_ready   = (state_q == ST_IDLE) && !scram_q && !ext_fault;
  assign accept      = cmd_valid && cmd_ready;
  assign pulse_start = accept && (chk_cause == CAUSE_NONE);

`ifdef SIGMA_SEQ_DUTY_LIMIT_EN
  localparam logic [2:0] CAUSE_DUTY = 3'b101;
  localparam int WIN_W  = (DUTY_WIN > 1) ? $clog2(DUTY_WIN) : 1;
  localparam int DCNT_W = (DUTY_MAX > 0) ? $clog2(DUTY_MAX + 1) : 1;

  logic [WIN_W-1:0]  win_q, win_d;
  logic [DCNT_W-1:0] duty_cnt_q, duty_cnt_d;
  logic              win_wrap;

  // Window counter free-runs; the accepted-pulse count restarts with each window.
  always_comb begin
    win_wrap   = (win_q == WIN_W'(DUTY_WIN - 1));
    win_d      = win_wrap ? '0 : (win_q + WIN_W'(1));
    duty_cnt_d = win_wrap ? '0 : duty_cnt_q;
    if (pulse_start) begin
      duty_cnt_d = duty_cnt_d + DCNT_W'(1);
    end
  end

  // Duty counter registers, cleared by reset like the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q      <= '0;
      duty_cnt_q <= '0;
    end else begin
      win_q      <= win_d;
      duty_cnt_q <= duty_cnt_d;
    end
  end
`endif

  // Command legality in priority order; the first failing check names the cause.
  always_comb begin
    chk_cause = CAUSE_NONE;
    if (int'(cmd_ch) >= CH_N) begin
      chk_cause = CAUSE_CH;
    end else if (int'(cmd_width) < MIN_TICKS) begin
      chk_cause = CAUSE_SHORT;
    end else if (int'(cmd_width) > MAX_TICKS) begin
      chk_cause = CAUSE_LONG;
    end
`ifdef SIGMA_SEQ_DUTY_LIMIT_EN
    else if (int'(duty_cnt_q) >= DUTY_MAX) begin
      chk_cause = CAUSE_DUTY;
    end
`endif
  end

  // Sequencer next state: ext_fault overrides everything, otherwise walk IDLE->PULSE->GAP->IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    done_d  = 1'b0;
    scram_d = scram_q;
    cause_d = cause_q;
    if (ext_fault) begin
      state_d = ST_SCRAM;
      pulse_d = '0;
      scram_d = 1'b1;
      cause_d = CAUSE_FAULT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (chk_cause != CAUSE_NONE) begin
              // Illegal command: latch the cause, never raise a pulse line.
              state_d = ST_SCRAM;
              scram_d = 1'b1;
              cause_d = chk_cause;
            end else begin
              // Width and channel are captured here; later input changes are ignored.
              state_d = ST_PULSE;
              cnt_d   = cmd_width - W_W'(1);
              pulse_d = CH_N'(1) << cmd_ch;
            end
          end
        end
        ST_PULSE: begin
          if (cnt_q == '0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
            pulse_d = '0;
          end else begin
            cnt_d = cnt_q - W_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - W_W'(1);
          end
        end
        ST_SCRAM: begin
          if (scram_clear) begin
            state_d = ST_IDLE;
            scram_d = 1'b0;
            cause_d = CAUSE_NONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          pulse_d = '0;
        end
      endcase
    end
    busy_d = (state_d == ST_PULSE) || (state_d == ST_GAP);
  end

  // State and registered outputs; reset drops pulse_out asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      scram_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      scram_q <= scram_d;
      cause_q <= cause_d;
    end
  end

  assign pulse_out    = pulse_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign safety_scram = scram_q;
  assign scram_cause  = cause_q;

  // Drive lines are mutually exclusive and only live while pulsing.
  a_pulse_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pulse_q));
  a_pulse_state:  assert property (@(posedge clk) disable iff (!rst_n) (pulse_q != '0) |-> (state_q == ST_PULSE));
  a_scram_state:  assert property (@(posedge clk) disable iff (!rst_n) scram_q == (state_q == ST_SCRAM));

endmodule
